// File: rtl/md_unit_if.sv
// Execute-stage multiply/divide unit bus: the operands and decoded md op
// come from the D/E pipeline register, and busy/HI/LO go back to the
// hazard unit and the MFHI/MFLO path.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues md ops and reads back HI/LO and busy.
    modport master (
        output start,
        output md_op,
        output src_a,
        output src_b,
        input  busy,
        input  hi,
        input  lo
    );

    // Unit side.
    modport slave (
        input  start,
        input  md_op,
        input  src_a,
        input  src_b,
        output busy,
        output hi,
        output lo
    );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
//
// The 64-bit result is computed in the cycle the op is issued and parked in
// tmp_hi/tmp_lo. The unit then stays busy for a fixed number of cycles
// before the parked result is copied into HI/LO, which mimics a
// multi-cycle iterative datapath.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO
//   ST_RUN   | op in flight; busy=1, counter counts down to completion
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    md_unit_if.slave md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LOAD_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      tmp_hi;
    logic [31:0]      tmp_lo;
    logic             tmp_wr;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             accept_md;
    logic             accept_mt;
    logic             run_done;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_signed;
    logic             div_by_zero;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [31:0]      safe_b;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;
    logic [CNT_W-1:0] res_cycles;

    // Only md ops issued while idle are taken; anything during RUN is dropped.
    assign accept_md = (state == ST_IDLE) && md.start && (md.md_op[2] == 1'b0);
    assign accept_mt = (state == ST_IDLE) && md.start &&
                       ((md.md_op == OP_MTHI) || (md.md_op == OP_MTLO));
    assign run_done  = (state == ST_RUN) && (cnt == CNT_TC);

    // Arithmetic datapath: products and sign-magnitude division.
    // Division goes through magnitudes so that MIN_INT / -1 wraps cleanly to
    // 0x80000000 instead of relying on signed-overflow behaviour.
    always_comb begin
        prod_s      = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};
        prod_u      = {32'd0, md.src_a} * {32'd0, md.src_b};
        div_signed  = (md.md_op == OP_DIV);
        div_by_zero = (md.src_b == 32'd0);
        mag_a       = (div_signed && md.src_a[31]) ? (~md.src_a + 32'd1) : md.src_a;
        mag_b       = (div_signed && md.src_b[31]) ? (~md.src_b + 32'd1) : md.src_b;
        safe_b      = div_by_zero ? 32'd1 : mag_b;
        q_mag       = mag_a / safe_b;
        r_mag       = mag_a % safe_b;
        quot        = (div_signed && (md.src_a[31] ^ md.src_b[31])) ? (~q_mag + 32'd1) : q_mag;
        rem         = (div_signed && md.src_a[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    // Select the result, write-back enable and busy length for the issued op.
    always_comb begin
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_wr     = 1'b0;
        res_cycles = LOAD_MULT;
        case (md.md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi     = rem;
                res_lo     = quot;
                res_wr     = ~div_by_zero;
                res_cycles = LOAD_DIV;
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    // FSM and busy down-counter; completion is the edge where the count is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_md) begin
                        state <= ST_RUN;
                        cnt   <= res_cycles;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_TC;
                    if (run_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Park the result at issue so later operand changes cannot affect it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            tmp_wr <= 1'b0;
        end else if (accept_md) begin
            tmp_hi <= res_hi;
            tmp_lo <= res_lo;
            tmp_wr <= res_wr;
        end
    end

    // Architectural HI/LO: updated at completion (unless divide by zero) or
    // directly by MTHI/MTLO while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (run_done) begin
            if (tmp_wr) begin
                hi_q <= tmp_hi;
                lo_q <= tmp_lo;
            end
        end else if (accept_mt) begin
            if (md.md_op == OP_MTHI) begin
                hi_q <= md.src_a;
            end else begin
                lo_q <= md.src_a;
            end
        end
    end

    assign md.busy = (state == ST_RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit with default latencies (MULT 5, DIV 10).
module tb_md_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    md_unit_if mdi ();

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        chk({tag, " busy"}, {31'd0, mdi.busy}, {31'd0, exp_busy});
        chk({tag, " hi"}, mdi.hi, exp_hi);
        chk({tag, " lo"}, mdi.lo, exp_lo);
    endtask

    // One-cycle issue of an md op, then return the inputs to a harmless no-op.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdi.start = 1'b1;
        mdi.md_op = op;
        mdi.src_a = a;
        mdi.src_b = b;
        tick();
        mdi.start = 1'b0;
        mdi.md_op = 3'd7;
    endtask

    // Expect n busy cycles with HI/LO holding their old values throughout.
    task automatic wait_busy(input string tag, input int n,
                             input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        for (int i = 0; i < n; i++) begin
            chk_all(tag, 1'b1, hold_hi, hold_lo);
            tick();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        mdi.start = 1'b0;
        mdi.md_op = 3'd7;
        mdi.src_a = 32'd0;
        mdi.src_b = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_all("reset", 1'b0, 32'h0, 32'h0);

        // MULT -1 * 2
        start_op(3'd0, 32'hFFFFFFFF, 32'h00000002);
        wait_busy("mult run", 5, 32'h0, 32'h0);
        chk_all("mult done", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);

        // MULTU, with src_a changed after issue
        start_op(3'd1, 32'hFFFFFFFF, 32'h00000002);
        chk_all("multu run", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        tick();
        mdi.src_a = 32'h0;
        wait_busy("multu run", 4, 32'hFFFFFFFF, 32'hFFFFFFFE);
        chk_all("multu done", 1'b0, 32'h00000001, 32'hFFFFFFFE);

        // DIV -7 / 2, issued back-to-back
        start_op(3'd2, 32'hFFFFFFF9, 32'h00000002);
        wait_busy("div run", 10, 32'h00000001, 32'hFFFFFFFE);
        chk_all("div done", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // DIV MIN_INT / -1
        start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_busy("div ovf run", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        chk_all("div ovf done", 1'b0, 32'h00000000, 32'h80000000);

        // DIVU 7 / 2
        start_op(3'd3, 32'h00000007, 32'h00000002);
        wait_busy("divu run", 10, 32'h0, 32'h80000000);
        chk_all("divu done", 1'b0, 32'h00000001, 32'h00000003);

        // DIVU by zero leaves HI/LO alone
        start_op(3'd3, 32'h00000005, 32'h00000000);
        wait_busy("divz run", 10, 32'h00000001, 32'h00000003);
        chk_all("divz done", 1'b0, 32'h00000001, 32'h00000003);

        // No-op with start=1 while idle
        start_op(3'd6, 32'hCAFEF00D, 32'h1);
        chk_all("nop idle", 1'b0, 32'h00000001, 32'h00000003);

        // MTHI / MTLO while idle
        start_op(3'd4, 32'h12345678, 32'h0);
        chk_all("mthi", 1'b0, 32'h12345678, 32'h00000003);
        start_op(3'd5, 32'hA5A5A5A5, 32'h0);
        chk_all("mtlo", 1'b0, 32'h12345678, 32'hA5A5A5A5);

        // MULT 3*4 with MTLO and a second MULT attempted during busy
        start_op(3'd0, 32'd3, 32'd4);
        chk_all("mult+mt run", 1'b1, 32'h12345678, 32'hA5A5A5A5);
        start_op(3'd5, 32'hDEADBEEF, 32'h0);
        chk_all("mult+mt run", 1'b1, 32'h12345678, 32'hA5A5A5A5);
        start_op(3'd0, 32'd100, 32'd100);
        wait_busy("mult+mt run", 3, 32'h12345678, 32'hA5A5A5A5);
        chk_all("mult+mt done", 1'b0, 32'h0, 32'd12);

        // Reset in the third busy cycle of a DIV aborts it
        start_op(3'd2, 32'd100, 32'd7);
        wait_busy("div abort run", 2, 32'h0, 32'd12);
        chk_all("div abort run", 1'b1, 32'h0, 32'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("div aborted", 1'b0, 32'h0, 32'h0);
        tick();
        chk_all("after abort", 1'b0, 32'h0, 32'h0);

        // Fresh MULT after abort
        start_op(3'd0, 32'd3, 32'd4);
        wait_busy("mult2 run", 5, 32'h0, 32'h0);
        chk_all("mult2 done", 1'b0, 32'h0, 32'd12);

        // Signed MULT of two negatives
        start_op(3'd0, 32'hFFFFFFF9, 32'hFFFFFFFE);
        wait_busy("mult neg run", 5, 32'h0, 32'd12);
        chk_all("mult neg done", 1'b0, 32'h0, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
